// File: rtl/transition_scan_scheduler.sv
// ============================================================================
// Module   : transition_scan_scheduler
// Purpose  : Round-robin scan of NCH serial lines through one shared edge
//            detector, with events delivered over a valid/ready port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module transition_scan_scheduler #(
  parameter int NCH  = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [NCH-1:0]   ch_in,
  input  logic [NCH-1:0]   ch_mask,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_ch,
  output logic             evt_dir,
  output logic [CNTW-1:0]  evt_total,
  output logic [IDW-1:0]   scan_ptr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } ch_state_t;

  localparam logic [IDW-1:0] c_last_ch = IDW'(NCH - 1);

  ch_state_t           r_state [NCH];
  logic [IDW-1:0]      r_scan_ptr;
  logic                r_evt_valid;
  logic [IDW-1:0]      r_evt_ch;
  logic                r_evt_dir;
  logic [CNTW-1:0]     r_evt_total;

  logic                w_stall;
  logic                w_active;
  logic                w_bit;
  logic                w_masked;
  ch_state_t           w_cur;
  ch_state_t           w_next;
  logic                w_det;
  logic                w_dir;

  assign w_stall  = r_evt_valid & ~evt_ready;
  assign w_active = en & ~w_stall;
  assign w_bit    = ch_in[r_scan_ptr];
  assign w_masked = ch_mask[r_scan_ptr];
  assign w_cur    = r_state[r_scan_ptr];

  // Next-state and event decode for the channel under the pointer.
  always_comb begin
    w_next = w_cur;
    w_det  = 1'b0;
    w_dir  = 1'b0;
    if (w_masked) begin
      w_next = ST_IDLE;
    end else begin
      case (w_cur)
        ST_IDLE: w_next = w_bit ? ST_HIGH : ST_LOW;
        ST_LOW: begin
          if (w_bit) begin
            w_next = ST_HIGH;
            w_det  = 1'b1;
            w_dir  = 1'b1;
          end
        end
        ST_HIGH: begin
          if (!w_bit) begin
            w_next = ST_LOW;
            w_det  = 1'b1;
            w_dir  = 1'b0;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) r_state[i] <= ST_IDLE;
      r_scan_ptr  <= '0;
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
      r_evt_dir   <= 1'b0;
      r_evt_total <= '0;
    end else if (clear) begin
      for (int i = 0; i < NCH; i++) r_state[i] <= ST_IDLE;
      r_scan_ptr  <= '0;
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
      r_evt_dir   <= 1'b0;
      r_evt_total <= '0;
    end else begin
      if (w_active) begin
        r_state[r_scan_ptr] <= w_next;
        r_scan_ptr <= (r_scan_ptr == c_last_ch) ? '0 : r_scan_ptr + 1'b1;
      end
      // A fresh detection overwrites a just-consumed event in the same edge.
      if (w_active && w_det) begin
        r_evt_valid <= 1'b1;
        r_evt_ch    <= r_scan_ptr;
        r_evt_dir   <= w_dir;
        if (r_evt_total != '1) r_evt_total <= r_evt_total + 1'b1;
      end else if (r_evt_valid && evt_ready) begin
        r_evt_valid <= 1'b0;
      end
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_ch    = r_evt_ch;
  assign evt_dir   = r_evt_dir;
  assign evt_total = r_evt_total;
  assign scan_ptr  = r_scan_ptr;

endmodule

`default_nettype wire
